// File: rtl/zle_param_enc.sv
// Zero run-length encoder: nonzero tokens pass, zero runs collapse to run tokens.
// Ports: clock/reset, input stream i_v/i_b/i_d/i_eos, output stream o_v/o_b/o_d/o_run/o_eos.
module zle_param_enc #(
  parameter int W       = 8,
  parameter int MAX_RUN = 16,
  parameter int CW      = $clog2(MAX_RUN + 1)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_v,
  output logic         i_b,
  input  logic [W-1:0] i_d,
  input  logic         i_eos,
  output logic         o_v,
  input  logic         o_b,
  output logic [W-1:0] o_d,
  output logic         o_run,
  output logic         o_eos
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ZEROS = 2'd1;
  localparam logic [1:0] S_PEND  = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_p_d;
  logic          r_p_eos;
  logic          r_v;
  logic [W-1:0]  r_d;
  logic          r_run;
  logic          r_eos;

  logic          w_free;
  logic          w_acc;
  logic          w_zero;
  logic [CW-1:0] w_inc;
  logic          w_full;
  logic          w_ld;
  logic [W-1:0]  w_ld_d;
  logic          w_ld_run;
  logic          w_ld_eos;
  logic          w_pld;
  logic [1:0]    w_nstate;
  logic [CW-1:0] w_ncnt;

  // slot is free when empty or being drained this cycle
  assign w_free = !r_v || !o_b;
  assign i_b    = (r_state == S_PEND) || (r_v && o_b);
  assign w_acc  = i_v && !i_b;
  assign w_zero = !i_eos && (i_d == '0);
  // cnt < MAX_RUN in ZEROS, so the increment never wraps
  assign w_inc  = r_cnt + CW'(1);
  assign w_full = (w_inc == CW'(MAX_RUN));

  always_comb begin
    w_ld     = 1'b0;
    w_ld_d   = '0;
    w_ld_run = 1'b0;
    w_ld_eos = 1'b0;
    w_pld    = 1'b0;
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          if (i_eos) begin
            w_ld     = 1'b1;
            w_ld_eos = 1'b1;
          end else if (w_zero) begin
            w_ncnt   = CW'(1);
            w_nstate = S_ZEROS;
          end else begin
            w_ld   = 1'b1;
            w_ld_d = i_d;
          end
        end
      end
      S_ZEROS: begin
        if (w_acc) begin
          if (w_zero && w_full) begin
            w_ld     = 1'b1;
            w_ld_d   = W'(MAX_RUN);
            w_ld_run = 1'b1;
            w_ncnt   = '0;
            w_nstate = S_IDLE;
          end else if (w_zero) begin
            w_ncnt = w_inc;
          end else begin
            w_ld     = 1'b1;
            w_ld_d   = W'(r_cnt);
            w_ld_run = 1'b1;
            w_pld    = 1'b1;
            w_ncnt   = '0;
            w_nstate = S_PEND;
          end
        end
      end
      S_PEND: begin
        if (w_free) begin
          w_ld     = 1'b1;
          w_ld_d   = r_p_d;
          w_ld_eos = r_p_eos;
          w_nstate = S_IDLE;
        end
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_p_d   <= '0;
      r_p_eos <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_cnt   <= w_ncnt;
      if (w_pld) begin
        r_p_d   <= i_eos ? '0 : i_d;
        r_p_eos <= i_eos;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_v   <= 1'b0;
      r_d   <= '0;
      r_run <= 1'b0;
      r_eos <= 1'b0;
    end else if (w_free) begin
      r_v <= w_ld;
      if (w_ld) begin
        r_d   <= w_ld_d;
        r_run <= w_ld_run;
        r_eos <= w_ld_eos;
      end
    end
  end

  assign o_v   = r_v;
  assign o_d   = r_d;
  assign o_run = r_run;
  assign o_eos = r_eos;

endmodule

// File: tb/tb_zle_param_enc.sv
// Bench for zle_param_enc: directed scenarios plus random traffic
// compared token-for-token against an RLE reference model.
module tb_zle_param_enc;

  localparam int MAXR = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       i_v = 1'b0;
  logic       i_b;
  logic [7:0] i_d = '0;
  logic       i_eos = 1'b0;
  logic       o_v;
  logic       o_b = 1'b0;
  logic [7:0] o_d;
  logic       o_run;
  logic       o_eos;

  int n_chk  = 0;
  int n_fail = 0;
  int ob_mode = 0;
  int ib_cnt = 0;

  logic [9:0] in_q[$];
  logic [9:0] out_q[$];

  zle_param_enc #(.W(8), .MAX_RUN(MAXR)) dut (
    .clock(clock), .reset(reset),
    .i_v(i_v), .i_b(i_b), .i_d(i_d), .i_eos(i_eos),
    .o_v(o_v), .o_b(o_b), .o_d(o_d), .o_run(o_run), .o_eos(o_eos)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (ob_mode == 0) o_b = 1'b0;
    else if (ob_mode == 1) o_b = ($urandom_range(0, 9) < 4);
  end

  always begin
    @(negedge clock);
    #2;
    if (reset && o_v && !o_b) out_q.push_back({o_eos, o_run, o_d});
    if (reset && i_b) ib_cnt++;
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // in_q entries: {eos, 1'b0, d}; model emits {eos, run, d}
  function automatic void rle_model(output logic [9:0] eq[$]);
    int c = 0;
    eq = {};
    foreach (in_q[k]) begin
      if (in_q[k][9]) begin
        if (c > 0) eq.push_back({2'b01, 8'(c)});
        eq.push_back(10'h200);
        c = 0;
      end else if (in_q[k][7:0] == 0) begin
        c++;
        if (c == MAXR) begin
          eq.push_back({2'b01, 8'(MAXR)});
          c = 0;
        end
      end else begin
        if (c > 0) eq.push_back({2'b01, 8'(c)});
        eq.push_back({2'b00, in_q[k][7:0]});
        c = 0;
      end
    end
  endfunction

  task automatic send(input bit eos, input logic [7:0] d, input int gap);
    int n = 0;
    repeat (gap) @(negedge clock);
    i_v   = 1'b1;
    i_eos = eos;
    i_d   = eos ? 8'($urandom) : d;
    forever begin
      #2;
      if (!i_b) break;
      @(negedge clock);
      n++;
      if (n > 2000) begin
        chk("send_timeout", 1, 0);
        break;
      end
    end
    in_q.push_back({eos, 1'b0, eos ? 8'h00 : d});
    @(negedge clock);
    i_v = 1'b0;
  endtask

  task automatic drain(string tag);
    logic [9:0] eq[$];
    int n = 0;
    rle_model(eq);
    while (out_q.size() < eq.size() && n < 4000) begin
      @(negedge clock);
      n++;
    end
    repeat (6) @(negedge clock);
    chk({tag, "_count"}, out_q.size(), eq.size());
    for (int k = 0; k < eq.size() && k < out_q.size(); k++)
      chk(tag, out_q[k], eq[k]);
    in_q  = {};
    out_q = {};
  endtask

  initial begin
    #2;
    chk("rst_ov", o_v, 0);
    chk("rst_od", o_d, 0);
    chk("rst_run", o_run, 0);
    chk("rst_eos", o_eos, 0);
    chk("rst_ib", i_b, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #2;
    chk("rel_ib", i_b, 0);
    @(negedge clock);

    // 5,0,0,0,7 back to back
    ob_mode = 0;
    ib_cnt  = 0;
    send(0, 8'd5, 0);
    #2;
    chk("lat_v", o_v, 1);
    chk("lat_tok", {o_eos, o_run, o_d}, 10'h005);
    @(negedge clock);
    send(0, 8'd0, 0);
    send(0, 8'd0, 0);
    send(0, 8'd0, 0);
    send(0, 8'd7, 0);
    drain("t1");
    chk("t1_ib_cycles", ib_cnt, 1);

    // 33 zeros then 9
    for (int k = 0; k < 33; k++) send(0, 8'd0, 0);
    send(0, 8'd9, 0);
    drain("t2");

    // 0,0,EOS then lone EOS
    send(0, 8'd0, 0);
    send(0, 8'd0, 0);
    send(1, 8'd0, 0);
    drain("t3a");
    send(1, 8'd0, 0);
    #2;
    chk("eos_lat_v", o_v, 1);
    chk("eos_lat_e", o_eos, 1);
    @(negedge clock);
    drain("t3b");

    // consumer stall of 4 cycles
    ob_mode = 2;
    o_b = 1'b0;
    send(0, 8'd3, 0);
    o_b   = 1'b1;
    i_v   = 1'b1;
    i_eos = 1'b0;
    i_d   = 8'd4;
    for (int k = 0; k < 4; k++) begin
      #2;
      chk("hold_v", o_v, 1);
      chk("hold_tok", {o_eos, o_run, o_d}, 10'h003);
      chk("hold_ib", i_b, 1);
      @(negedge clock);
    end
    o_b = 1'b0;
    #2;
    chk("rel_ib2", i_b, 0);
    in_q.push_back(10'h004);
    @(negedge clock);
    i_v = 1'b0;
    send(0, 8'd6, 0);
    drain("t4");

    // random traffic
    ob_mode = 1;
    for (int k = 0; k < 10000; k++) begin
      bit e;
      logic [7:0] d;
      e = ($urandom_range(0, 49) == 0);
      d = $urandom_range(0, 1) ? 8'd0 : 8'($urandom_range(1, 255));
      send(e, d, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
    end
    send(0, 8'd1, 0);
    ob_mode = 0;
    drain("t5");

    // reset in the middle of a run
    for (int k = 0; k < 5; k++) send(0, 8'd0, 0);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_rst_ov", o_v, 0);
    chk("mid_rst_ib", i_b, 0);
    @(negedge clock);
    reset = 1'b1;
    in_q  = {};
    out_q = {};
    send(0, 8'd4, 0);
    drain("t6");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
